cla: RTL and testbench

CLA -- requirements
Module: cla

---
 rtl/cla.sv | 123 ++++++++++++
 tb/tb_cla.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla.sv
// Registered two-level carry-lookahead adder.
// Computes {Cout,S} = A + B + Cin. 4-bit blocks produce group propagate and
// generate; a second lookahead level forms every block carry-in directly
// from Cin and the group terms. Result is registered, one cycle latency.
// Optional macro CLA_OVF_EN adds the registered signed-overflow output Ovf.
module cla #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] S,
`ifdef CLA_OVF_EN
    output logic             Ovf,
`endif
    output logic             Cout
);
    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_g;
    logic [WIDTH:0]   w_c;
    logic [NG-1:0]    w_gp;
    logic [NG-1:0]    w_gg;
    logic [NG:0]      w_bc;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    assign w_p = A ^ B;
    assign w_g = A & B;

    // First level: expanded sum-of-products carries inside each 4-bit block,
    // plus the block's group propagate and group generate.
    for (genvar b = 0; b < NG; b++) begin : g_blk
        logic [3:0] w_bp;
        logic [3:0] w_bg;
        logic       w_ci;

        assign w_bp = w_p[4*b +: 4];
        assign w_bg = w_g[4*b +: 4];
        assign w_ci = w_bc[b];

        assign w_c[4*b]     = w_ci;
        assign w_c[4*b + 1] = w_bg[0]
                            | (w_bp[0] & w_ci);
        assign w_c[4*b + 2] = w_bg[1]
                            | (w_bp[1] & w_bg[0])
                            | (w_bp[1] & w_bp[0] & w_ci);
        assign w_c[4*b + 3] = w_bg[2]
                            | (w_bp[2] & w_bg[1])
                            | (w_bp[2] & w_bp[1] & w_bg[0])
                            | (w_bp[2] & w_bp[1] & w_bp[0] & w_ci);

        assign w_gp[b] = &w_bp;
        assign w_gg[b] = w_bg[3]
                       | (w_bp[3] & w_bg[2])
                       | (w_bp[3] & w_bp[2] & w_bg[1])
                       | (w_bp[3] & w_bp[2] & w_bp[1] & w_bg[0]);
    end

    assign w_c[WIDTH] = w_bc[NG];

    // Second level: each block carry-in as a flat sum-of-products over Cin
    // and the group terms, so no block waits on its neighbour's carry.
    always_comb begin
        logic w_acc;
        logic w_term;
        w_bc   = '0;
        w_acc  = 1'b0;
        w_term = 1'b0;
        for (int j = 0; j <= NG; j++) begin
            w_term = Cin;
            for (int m = 0; m < j; m++) begin
                w_term = w_term & w_gp[m];
            end
            w_acc = w_term;
            for (int k = 0; k < j; k++) begin
                w_term = w_gg[k];
                for (int m = k + 1; m < j; m++) begin
                    w_term = w_term & w_gp[m];
                end
                w_acc = w_acc | w_term;
            end
            w_bc[j] = w_acc;
        end
    end

    assign w_sum = w_p ^ w_c[WIDTH-1:0];

    // Result register; reset wins over the operation presented that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_c[WIDTH];
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;

`ifdef CLA_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
        end
    end

    assign Ovf = r_ovf;
`endif

endmodule

// File: tb/tb_cla.sv
// Self-checking bench for cla: directed vectors, boundaries, reset behaviour,
// back-to-back operation and randomized vectors against an arithmetic model.
module tb_cla;
    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
`ifdef CLA_OVF_EN
    logic         ovf;
`endif

    int n_checks;
    int n_errors;

    cla #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (a),
        .B    (b),
        .Cin  (cin),
        .S    (s),
`ifdef CLA_OVF_EN
        .Ovf  (ovf),
`endif
        .Cout (cout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain wide addition; overflow from operand/result signs.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        logic [W:0] wide;
        wide = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return wide;
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
        logic [W:0] r;
        r = ref_sum(x, y, c);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // driver: present inputs at negedge, let one rising edge pass, settle
    task automatic drive(input logic r, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c);
        @(negedge clk);
        rst = r;
        a   = x;
        b   = y;
        cin = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            n_checks++;
            if (s !== '0 || cout !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_%0d: S=%h Cout=%b expected S=0 Cout=0", i, s, cout);
            end
`ifdef CLA_OVF_EN
            n_checks++;
            if (ovf !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_ovf_%0d: Ovf=%b expected 0", i, ovf);
            end
`endif
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va[4];
        logic [W-1:0] vb[4];
        logic         vc[4];
        logic [W:0]   e;
        va = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_ABCD, 32'h7FFF_FFFF};
        vb = '{32'h0000_0005, 32'h0000_0001, 32'h0000_1234, 32'h0000_0001};
        vc = '{1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, va[i], vb[i], vc[i]);
            e = ref_sum(va[i], vb[i], vc[i]);
            n_checks++;
            if (s !== e[W-1:0] || cout !== e[W]) begin
                n_errors++;
                $display("FAIL directed_%0d: S=%h Cout=%b expected S=%h Cout=%b",
                         i, s, cout, e[W-1:0], e[W]);
            end
`ifdef CLA_OVF_EN
            n_checks++;
            if (ovf !== ref_ovf(va[i], vb[i], vc[i])) begin
                n_errors++;
                $display("FAIL directed_ovf_%0d: Ovf=%b expected %b",
                         i, ovf, ref_ovf(va[i], vb[i], vc[i]));
            end
`endif
        end
        // Literal expectations for the documented vectors.
        drive(1'b0, 32'h0000_0003, 32'h0000_0005, 1'b0);
        n_checks++;
        if (s !== 32'h0000_0008 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL vec_3p5: S=%h Cout=%b expected S=00000008 Cout=0", s, cout);
        end
        drive(1'b0, 32'h0000_ABCD, 32'h0000_1234, 1'b1);
        n_checks++;
        if (s !== 32'h0000_BE02 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL vec_abcd: S=%h Cout=%b expected S=0000be02 Cout=0", s, cout);
        end
`ifdef CLA_OVF_EN
        drive(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        n_checks++;
        if (s !== 32'h8000_0000 || cout !== 1'b0 || ovf !== 1'b1) begin
            n_errors++;
            $display("FAIL vec_ovf: S=%h Cout=%b Ovf=%b expected S=80000000 Cout=0 Ovf=1",
                     s, cout, ovf);
        end
`endif
    endtask

    task automatic test_boundary();
        drive(1'b0, '1, 32'h1, 1'b0);
        n_checks++;
        if (s !== '0 || cout !== 1'b1) begin
            n_errors++;
            $display("FAIL wrap: S=%h Cout=%b expected S=00000000 Cout=1", s, cout);
        end
        drive(1'b0, '1, '1, 1'b1);
        n_checks++;
        if (s !== '1 || cout !== 1'b1) begin
            n_errors++;
            $display("FAIL ones_ones_cin: S=%h Cout=%b expected S=ffffffff Cout=1", s, cout);
        end
        drive(1'b0, '0, '0, 1'b0);
        n_checks++;
        if (s !== '0 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL zeros: S=%h Cout=%b expected S=00000000 Cout=0", s, cout);
        end
        // Fully propagating chain: Cin ripples through every block to Cout.
        drive(1'b0, 32'hA5A5_5A5A, 32'h5A5A_A5A5, 1'b1);
        n_checks++;
        if (s !== '0 || cout !== 1'b1) begin
            n_errors++;
            $display("FAIL propagate_chain: S=%h Cout=%b expected S=00000000 Cout=1", s, cout);
        end
        drive(1'b0, 32'hA5A5_5A5A, 32'h5A5A_A5A5, 1'b0);
        n_checks++;
        if (s !== '1 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL propagate_nocin: S=%h Cout=%b expected S=ffffffff Cout=0", s, cout);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] va[3];
        logic [W-1:0] vb[3];
        logic         vc[3];
        logic [W:0]   exp_q[$];
        logic [W:0]   e;
        va = '{32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_ABCD};
        vb = '{32'h0000_0005, 32'h0000_0001, 32'h0000_1234};
        vc = '{1'b0, 1'b0, 1'b1};
        // establish a known prior result distinct from all three
        drive(1'b0, 32'h1234_0000, 32'h0000_0001, 1'b0);
        exp_q.push_back(ref_sum(32'h1234_0000, 32'h0000_0001, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_checks++;
            if ({cout, s} !== e) begin
                n_errors++;
                $display("FAIL b2b_hold_%0d: {Cout,S}=%h expected %h", i, {cout, s}, e);
            end
            rst = 1'b0;
            a   = va[i];
            b   = vb[i];
            cin = vc[i];
            exp_q.push_back(ref_sum(va[i], vb[i], vc[i]));
            @(posedge clk);
            #1;
            n_checks++;
            if ({cout, s} !== exp_q[0]) begin
                n_errors++;
                $display("FAIL b2b_%0d: {Cout,S}=%h expected %h", i, {cout, s}, exp_q[0]);
            end
        end
    endtask

    task automatic test_reset_priority();
        logic [W:0] e;
        drive(1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0);
        drive(1'b1, '1, '1, 1'b1);
        n_checks++;
        if (s !== '0 || cout !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_priority: S=%h Cout=%b expected S=0 Cout=0", s, cout);
        end
        drive(1'b0, '1, '1, 1'b1);
        e = ref_sum('1, '1, 1'b1);
        n_checks++;
        if (s !== 32'hFFFF_FFFF || cout !== 1'b1 || {cout, s} !== e) begin
            n_errors++;
            $display("FAIL reset_release: S=%h Cout=%b expected S=ffffffff Cout=1", s, cout);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        logic [W:0]   e;
        int           errs_before;
        errs_before = n_errors;
        for (int i = 0; i < 10000; i++) begin
            x = $urandom;
            y = $urandom;
            c = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: y = ~x;
                1: x = '1;
                2: y = 32'h8000_0000;
                default: ;
            endcase
            drive(1'b0, x, y, c);
            e = ref_sum(x, y, c);
            n_checks++;
            if ({cout, s} !== e) begin
                n_errors++;
                if (n_errors - errs_before <= 10)
                    $display("FAIL random_%0d: A=%h B=%h Cin=%b got {Cout,S}=%h expected %h",
                             i, x, y, c, {cout, s}, e);
            end
`ifdef CLA_OVF_EN
            n_checks++;
            if (ovf !== ref_ovf(x, y, c)) begin
                n_errors++;
                if (n_errors - errs_before <= 10)
                    $display("FAIL random_ovf_%0d: A=%h B=%h Cin=%b Ovf=%b expected %b",
                             i, x, y, c, ovf, ref_ovf(x, y, c));
            end
`endif
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        a   = '0;
        b   = '0;
        cin = 1'b0;
        test_reset();
        test_directed();
        test_boundary();
        test_back_to_back();
        test_reset_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
